shift_add_mult: RTL and testbench

//   Sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier built around a single WIDTH-bit adder with carry-out.

---
 rtl/shift_add_mult.sv | 105 ++++++++++
 tb/tb_shift_add_mult.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/shift_add_mult.sv
// Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier, one iteration per clock, valid/ready on both sides.
// Optional build macro ZERO_BYPASS_EN: a zero operand skips RUN and completes straight into DONE.
module shift_add_mult #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand, hi, lo, hi_nxt, lo_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;
  logic             accept, zero_op, last_iter;

  // Adder result kept at WIDTH+1 bits so the carry shifts into hi[WIDTH-1].
  always_comb begin
    sum    = lo[0] ? ({1'b0, hi} + {1'b0, mcand}) : {1'b0, hi};
    hi_nxt = sum[WIDTH:1];
    lo_nxt = {sum[0], lo[WIDTH-1:1]};
  end

  assign accept    = (state == IDLE) && in_valid;
  assign last_iter = (cnt == LAST);

`ifdef ZERO_BYPASS_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = zero_op ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // product is a separate register so it stays put through IDLE and RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
            if (zero_op) begin
              lo      <= '0;
              product <= '0;
            end
          end
        end
        RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + CW'(1);
          if (last_iter) product <= {hi_nxt, lo_nxt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult (WIDTH=32): vector table, directed corner sequences, random ops vs a*b.
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int total = 0;
  int bad   = 0;

  shift_add_mult #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [63:0] vp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef ZERO_BYPASS_EN
    return (x == 0 || y == 0) ? 0 : 32;
`else
    return 32;
`endif
  endfunction

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint unsigned px, py;
    px = longint'(x);
    py = longint'(y);
    return 64'(px * py);
  endfunction

  // Accept one op, wait for the result, stall `stall` cycles, then handshake.
  // hold_valid keeps in_valid high with operands 9,9 after the accept edge.
  task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [63:0] exp, input int stall, input bit hold_valid);
    int lat;
    check({name, " in_ready_pre"}, 64'(in_ready), 64'd1);
    a = ta; b = tb_; in_valid = 1'b1; out_ready = (stall == 0);
    @(posedge clk); #1;
    if (hold_valid) begin a = 32'd9; b = 32'd9; end
    else begin in_valid = 1'b0; a = $urandom; b = $urandom; end
    check({name, " busy_after_accept"}, 64'(busy), 64'(exp_lat(ta, tb_) != 0));
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (lat > 0) check({name, " in_ready_run"}, 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat(ta, tb_)));
    check({name, " product"}, product, exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({name, " stall_flags"}, {62'd0, out_valid, in_ready}, 64'd2);
      check({name, " stall_product"}, product, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, " post_handshake"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;

    vecs[0] = '{32'd3,          32'd5,          64'd15};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,          32'd1234,       64'd0};
    vecs[3] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
    vecs[4] = '{32'h8000_0000,  32'd2,          64'h1_0000_0000};
    vecs[5] = '{32'd100000,     32'd100000,     64'd10000000000};
    vecs[6] = '{32'd4321,       32'd0,          64'd0};

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset product", product, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vp, 0, 1'b0);

    // Stalled consumer with in_valid held high: no second accept until handshake.
    run_op("stall10", 32'd60000000, 32'd3789621, 64'd227377260000000, 10, 1'b1);
    run_op("after_stall", 32'd9, 32'd9, 64'd81, 0, 1'b0);

    // Reset mid-RUN at cnt=10 aborts the op; product was nonzero before.
    a = 32'd1000; b = 32'd1000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrun busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort product", product, 64'd0);
    run_op("after_abort", 32'd7, 32'd9, 64'd63, 0, 1'b0);

    // Back-to-back: run_op accepts on the edge right after the previous handshake.
    run_op("b2b_first", 32'd2, 32'd3, 64'd6, 0, 1'b0);
    run_op("b2b_second", 32'd65536, 32'd65536, 64'h1_0000_0000, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      int mode;
      mode = $urandom_range(0, 3);
      ra = $urandom; rb = $urandom;
      case (mode)
        1: begin ra = ra & 32'hFF; rb = rb & 32'hFF; end
        2: if (ra[0]) ra = '0; else rb = '0;
        3: begin ra = ra | 32'hFFFF_0000; rb = rb | 32'hFFFF_0000; end
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), ra, rb, ref_mul(ra, rb), $urandom_range(0, 3), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
